sdram_mport_arb: RTL and testbench

//  Multi-port front end for the SDRAM local bus (inb_* side of avalon2memwr).

---
 rtl/sdram_mport_arb_pkg.sv | 21 ++
 rtl/sdram_req_fifo.sv | 45 ++++
 rtl/sdram_mport_arb.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_mport_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_mport_arb_pkg.sv
// Shared constants, parameter defaults and FSM encoding for the multi-port SDRAM front end.
// No logic; latency n/a.
// Backpressure n/a.
package sdram_mport_arb_pkg;
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int DEF_DATA_NBIT = 16;
    localparam int DEF_ADDR_NBIT = 16;
    localparam int DEF_NCH       = 2;
    localparam int DEF_FIFO_AW   = 3;
    localparam int DEF_TAG_AW    = 3;
    localparam int DEF_RD_PRIO   = 0;

    typedef enum logic [1:0] {S_WAIT_INIT, S_IDLE, S_CMD} state_e;

    // A single channel still needs a 1-bit tag so the tag FIFO has a legal width.
    function automatic int tag_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction
endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on pop_dat whenever !empty.
// Latency: push visible at the head one cycle later.
// Backpressure: push on full is ignored unless a pop happens in the same cycle.
module sdram_req_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // The slot freed by a simultaneous pop is the one the push lands in.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/sdram_mport_arb.sv
// N-channel write/read request arbiter onto a single-command SDRAM local bus with tagged in-order read return.
// Latency: request to command strobe 2 clk when idle; read data to ch_rdv 1 clk after mem_datavalid.
// Backpressure: command held until mem_ready; full request FIFOs drop and flag ch_ovf; reads stall on full tag FIFO.
module sdram_mport_arb
    import sdram_mport_arb_pkg::*;
#(
    parameter int P_DATA_NBIT = DEF_DATA_NBIT,
    parameter int P_ADDR_NBIT = DEF_ADDR_NBIT,
    parameter int P_NCH       = DEF_NCH,
    parameter int P_FIFO_AW   = DEF_FIFO_AW,
    parameter int P_TAG_AW    = DEF_TAG_AW,
    parameter int P_RD_PRIO   = DEF_RD_PRIO
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [P_NCH-1:0]               ch_wren,
    input  logic [P_NCH*P_ADDR_NBIT-1:0]   ch_waddr,
    input  logic [P_NCH*P_DATA_NBIT-1:0]   ch_wdata,
    output logic [P_NCH-1:0]               ch_wempty,
    output logic [P_NCH-1:0]               ch_wfull,
    input  logic [P_NCH-1:0]               ch_rd,
    input  logic [P_NCH*P_ADDR_NBIT-1:0]   ch_raddr,
    output logic [P_NCH-1:0]               ch_rempty,
    output logic [P_NCH-1:0]               ch_rfull,
    output logic [P_DATA_NBIT-1:0]         ch_rdata,
    output logic [P_NCH-1:0]               ch_rdv,
    output logic [P_NCH-1:0]               ch_ovf,
    output logic                           err_orphan,
    input  logic                           mem_initdone,
    input  logic                           mem_ready,
    output logic [P_ADDR_NBIT-1:0]         mem_address,
    output logic                           mem_write,
    output logic [P_DATA_NBIT-1:0]         mem_wdata,
    output logic                           mem_read,
    input  logic [P_DATA_NBIT-1:0]         mem_rdata,
    input  logic                           mem_datavalid
);
    localparam int   NREQ    = 2 * P_NCH;
    localparam int   RQW     = $clog2(NREQ);
    localparam int   TW      = tag_w(P_NCH);
    localparam logic RD_PRIO = (P_RD_PRIO != 0);

    typedef struct packed {
        logic [P_ADDR_NBIT-1:0] addr;
        logic [P_DATA_NBIT-1:0] data;
    } wreq_t;

    state_e                 state;
    state_e                 state_nxt;
    logic                   init_s1;
    logic                   init_s2;
    logic                   init_ok;
    logic [RQW-1:0]         rr_ptr;
    logic [RQW-1:0]         gnt_idx;
    logic [RQW:0]           arb_idx;
    logic [TW-1:0]          gnt_ch;
    logic                   gnt_found;
    logic                   gnt_vld;
    logic                   cmd_acc;
    logic [NREQ-1:0]        req;
    logic [P_NCH-1:0]       w_empty, w_full, w_pop, w_req;
    logic [P_NCH-1:0]       r_empty, r_full, r_pop, r_req;
    logic                   rd_any;
    wreq_t                  w_dat [P_NCH];
    logic [P_ADDR_NBIT-1:0] r_dat [P_NCH];
    logic                   cmd_rd;
    logic [TW-1:0]          cmd_ch;
    logic [P_ADDR_NBIT-1:0] cmd_addr;
    logic [P_DATA_NBIT-1:0] cmd_data;
    logic                   tag_push;
    logic                   tag_empty;
    logic                   tag_full;
    logic [TW-1:0]          tag_dat;

    assign init_ok = init_s1 && init_s2;
    assign rd_any  = RD_PRIO && (|r_req);

    for (genvar i = 0; i < P_NCH; i++) begin : g_ch
        sdram_req_fifo #(.WIDTH($bits(wreq_t)), .AW(P_FIFO_AW)) u_wfifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (ch_wren[i]),
            .push_dat ({ch_waddr[i*P_ADDR_NBIT +: P_ADDR_NBIT], ch_wdata[i*P_DATA_NBIT +: P_DATA_NBIT]}),
            .pop      (w_pop[i]),
            .pop_dat  (w_dat[i]),
            .empty    (w_empty[i]),
            .full     (w_full[i])
        );

        sdram_req_fifo #(.WIDTH(P_ADDR_NBIT), .AW(P_FIFO_AW)) u_rfifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (ch_rd[i]),
            .push_dat (ch_raddr[i*P_ADDR_NBIT +: P_ADDR_NBIT]),
            .pop      (r_pop[i]),
            .pop_dat  (r_dat[i]),
            .empty    (r_empty[i]),
            .full     (r_full[i])
        );

        assign w_pop[i]     = gnt_vld && (gnt_idx == RQW'(2*i));
        assign r_pop[i]     = gnt_vld && (gnt_idx == RQW'(2*i+1));
        assign w_req[i]     = !w_empty[i];
        assign r_req[i]     = !r_empty[i] && !tag_full;
        assign req[2*i]     = w_req[i] && !rd_any;
        assign req[2*i+1]   = r_req[i];
    end

    assign ch_wempty = w_empty;
    assign ch_wfull  = w_full;
    assign ch_rempty = r_empty;
    assign ch_rfull  = r_full;

    // Scan from rr_ptr downwards in priority so the requester closest after rr_ptr wins last.
    always_comb begin
        gnt_found = LOW;
        gnt_idx   = '0;
        arb_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            arb_idx = {1'b0, rr_ptr} + (RQW+1)'(k);
            if (arb_idx >= (RQW+1)'(NREQ)) arb_idx = arb_idx - (RQW+1)'(NREQ);
            if (req[arb_idx[RQW-1:0]]) begin
                gnt_found = HIGH;
                gnt_idx   = arb_idx[RQW-1:0];
            end
        end
    end

    assign gnt_vld  = (state == S_IDLE) && init_ok && gnt_found;
    assign gnt_ch   = TW'(gnt_idx >> 1);
    assign cmd_acc  = (state == S_CMD) && init_ok && mem_ready;
    assign tag_push = cmd_acc && cmd_rd;

    always_comb begin
        state_nxt = state;
        mem_write = LOW;
        mem_read  = LOW;
        case (state)
            S_WAIT_INIT: if (init_ok) state_nxt = S_IDLE;
            S_IDLE:      if (gnt_vld) state_nxt = S_CMD;
            S_CMD: begin
                // Losing init only masks the strobe; the latched command survives for re-issue.
                mem_write = init_ok && !cmd_rd;
                mem_read  = init_ok && cmd_rd;
                if (cmd_acc) state_nxt = S_IDLE;
            end
            default:     state_nxt = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT_INIT;
            init_s1  <= LOW;
            init_s2  <= LOW;
            rr_ptr   <= '0;
            cmd_rd   <= LOW;
            cmd_ch   <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
        end else begin
            state   <= state_nxt;
            init_s1 <= mem_initdone;
            init_s2 <= init_s1;
            if (gnt_vld) begin
                rr_ptr <= (gnt_idx == RQW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                cmd_rd <= gnt_idx[0];
                cmd_ch <= gnt_ch;
                if (gnt_idx[0]) begin
                    cmd_addr <= r_dat[gnt_ch];
                end else begin
                    cmd_addr <= w_dat[gnt_ch].addr;
                    cmd_data <= w_dat[gnt_ch].data;
                end
            end
        end
    end

    assign mem_address = cmd_addr;
    assign mem_wdata   = cmd_data;

    sdram_req_fifo #(.WIDTH(TW), .AW(P_TAG_AW)) u_tagfifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tag_push),
        .push_dat (cmd_ch),
        .pop      (mem_datavalid),
        .pop_dat  (tag_dat),
        .empty    (tag_empty),
        .full     (tag_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_rdv     <= '0;
            ch_rdata   <= '0;
            ch_ovf     <= '0;
            err_orphan <= LOW;
        end else begin
            ch_rdv <= '0;
            ch_ovf <= ch_ovf | (ch_wren & w_full & ~w_pop) | (ch_rd & r_full & ~r_pop);
            if (mem_datavalid) begin
                if (tag_empty) begin
                    err_orphan <= HIGH;
                end else begin
                    ch_rdata        <= mem_rdata;
                    ch_rdv[tag_dat] <= HIGH;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_mport_arb.sv
// Directed scenarios plus a randomized run scored against per-channel request queues and an in-order return queue.
module tb_sdram_mport_arb;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_wren;
    logic [NCH*16-1:0] ch_waddr;
    logic [NCH*16-1:0] ch_wdata;
    logic [NCH-1:0]    ch_wempty;
    logic [NCH-1:0]    ch_wfull;
    logic [NCH-1:0]    ch_rd;
    logic [NCH*16-1:0] ch_raddr;
    logic [NCH-1:0]    ch_rempty;
    logic [NCH-1:0]    ch_rfull;
    logic [15:0]       ch_rdata;
    logic [NCH-1:0]    ch_rdv;
    logic [NCH-1:0]    ch_ovf;
    logic              err_orphan;
    logic              mem_initdone;
    logic              mem_ready;
    logic [15:0]       mem_address;
    logic              mem_write;
    logic [15:0]       mem_wdata;
    logic              mem_read;
    logic [15:0]       mem_rdata;
    logic              mem_datavalid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending requests per channel, and accepted reads awaiting return.
    logic [31:0] wq [NCH][$];
    logic [15:0] rq [NCH][$];
    logic [16:0] retq [$];
    logic [1:0]  exp_rdv;
    logic [15:0] exp_rdata;
    int          seq;

    sdram_mport_arb #(
        .P_DATA_NBIT(16), .P_ADDR_NBIT(16), .P_NCH(NCH),
        .P_FIFO_AW(3), .P_TAG_AW(3), .P_RD_PRIO(1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch_wren       (ch_wren),
        .ch_waddr      (ch_waddr),
        .ch_wdata      (ch_wdata),
        .ch_wempty     (ch_wempty),
        .ch_wfull      (ch_wfull),
        .ch_rd         (ch_rd),
        .ch_raddr      (ch_raddr),
        .ch_rempty     (ch_rempty),
        .ch_rfull      (ch_rfull),
        .ch_rdata      (ch_rdata),
        .ch_rdv        (ch_rdv),
        .ch_ovf        (ch_ovf),
        .err_orphan    (err_orphan),
        .mem_initdone  (mem_initdone),
        .mem_ready     (mem_ready),
        .mem_address   (mem_address),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_read      (mem_read),
        .mem_rdata     (mem_rdata),
        .mem_datavalid (mem_datavalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        ch_wren = '0;
        ch_rd   = '0;
    endtask

    task automatic drive_w(input int c, input logic [15:0] a, input logic [15:0] d);
        ch_wren[c]         = 1'b1;
        ch_waddr[c*16 +: 16] = a;
        ch_wdata[c*16 +: 16] = d;
    endtask

    task automatic drive_r(input int c, input logic [15:0] a);
        ch_rd[c]             = 1'b1;
        ch_raddr[c*16 +: 16] = a;
    endtask

    task automatic do_reset(input logic init);
        rst_n = 1'b0;
        clear_req();
        ch_waddr = '0; ch_wdata = '0; ch_raddr = '0;
        mem_initdone = init; mem_ready = 1'b0;
        mem_rdata = '0; mem_datavalid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    // Returns the next command the bus accepts, or ok=0 if none within the budget.
    task automatic wait_cmd(input int budget, output logic [15:0] a, output logic [15:0] d,
                            output logic rd, output bit ok);
        ok = 1'b0; a = '0; d = '0; rd = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if ((mem_write || mem_read) && mem_ready) begin
                ok = 1'b1; a = mem_address; d = mem_wdata; rd = mem_read;
            end
            step();
        end
    endtask

    task automatic ret_one(input string tag, input logic [15:0] data, input logic [1:0] rdv);
        mem_datavalid = 1'b1;
        mem_rdata     = data;
        step();
        mem_datavalid = 1'b0;
        chk({tag, "_rdv"}, ch_rdv, rdv);
        chk({tag, "_rdata"}, ch_rdata, data);
    endtask

    task automatic rand_cycle(input bit gen);
        logic [31:0] e;
        logic [16:0] r;
        logic [15:0] a;
        int          c;
        chk("rand_rdv", ch_rdv, exp_rdv);
        if (exp_rdv != 2'b00) chk("rand_rdata", ch_rdata, exp_rdata);
        exp_rdv = 2'b00;
        mem_datavalid = 1'b0;
        if (retq.size() > 0 && (!gen || $urandom_range(0, 1) == 1)) begin
            r = retq.pop_front();
            mem_datavalid = 1'b1;
            mem_rdata     = r[15:0];
            exp_rdv       = 2'b01 << r[16];
            exp_rdata     = r[15:0];
        end
        mem_ready    = gen ? ($urandom_range(0, 2) != 0) : 1'b1;
        mem_initdone = gen ? ($urandom_range(0, 39) != 0) : 1'b1;
        clear_req();
        chk("rand_one_strobe", {31'b0, mem_write & mem_read}, 0);
        if (mem_write && mem_ready) begin
            c = int'(mem_address[12]);
            chk("rand_wr_known", {30'b0, mem_address[15:13] == 3'b000, wq[c].size() > 0}, 3);
            if (wq[c].size() > 0) begin
                e = wq[c].pop_front();
                chk("rand_wr_addr", mem_address, e[31:16]);
                chk("rand_wr_data", mem_wdata, e[15:0]);
            end
        end
        if (mem_read && mem_ready) begin
            c = int'(mem_address[12]);
            chk("rand_rd_known", {30'b0, mem_address[15:13] == 3'b100, rq[c].size() > 0}, 3);
            if (rq[c].size() > 0) begin
                a = rq[c].pop_front();
                chk("rand_rd_addr", mem_address, a);
                retq.push_back({c[0], a ^ 16'hC3A5});
            end
        end
        if (gen) begin
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 3) == 0 && wq[k].size() < 6) begin
                    seq++;
                    a = {3'b000, k[0], seq[11:0]};
                    e = {a, 16'($urandom)};
                    drive_w(k, e[31:16], e[15:0]);
                    wq[k].push_back(e);
                end
                if ($urandom_range(0, 3) == 0 && rq[k].size() < 6) begin
                    seq++;
                    a = {3'b100, k[0], seq[11:0]};
                    drive_r(k, a);
                    rq[k].push_back(a);
                end
            end
        end
        step();
    endtask

    initial begin
        logic [15:0] a, d;
        logic        rd;
        bit          ok;
        int          cnt;
        bit          seen;

        // Reset state
        do_reset(1'b0);
        rst_n = 1'b0;
        step();
        chk("rst_mem_write", {31'b0, mem_write}, 0);
        chk("rst_mem_read", {31'b0, mem_read}, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_wempty", ch_wempty, 2'b11);
        chk("rst_rempty", ch_rempty, 2'b11);
        chk("rst_full", {ch_wfull, ch_rfull}, 0);
        chk("rst_flags", {ch_rdv, ch_ovf, err_orphan}, 0);
        rst_n = 1'b1;
        step();

        // 1: write queued before init completes
        drive_w(0, 16'h0010, 16'hBEEF);
        step();
        clear_req();
        chk("t1_wempty", ch_wempty, 2'b10);
        seen = 1'b0;
        repeat (5) begin
            seen |= mem_write;
            step();
        end
        chk("t1_no_write_preinit", {31'b0, seen}, 0);
        mem_initdone = 1'b1;
        cnt = 0;
        while (cnt < 20 && mem_write !== 1'b1) begin
            step();
            cnt++;
        end
        chk("t1_latency", {31'b0, cnt >= 3 && cnt < 20}, 1);
        chk("t1_addr", mem_address, 16'h0010);
        chk("t1_data", mem_wdata, 16'hBEEF);

        // 2: simultaneous writes alternate between channels
        do_reset(1'b1);
        repeat (4) step();
        drive_w(0, 16'h0100, 16'hAAAA); drive_w(1, 16'h0200, 16'h5555);
        step();
        drive_w(0, 16'h0101, 16'hAAAB); drive_w(1, 16'h0201, 16'h5556);
        step();
        clear_req();
        mem_ready = 1'b1;
        wait_cmd(10, a, d, rd, ok);
        chk("t2_c0", {ok, rd, a, d[13:0]}, {1'b1, 1'b0, 16'h0100, 14'h2AAA});
        wait_cmd(10, a, d, rd, ok);
        chk("t2_c1", {ok, rd, a, d[13:0]}, {1'b1, 1'b0, 16'h0200, 14'h1555});
        wait_cmd(10, a, d, rd, ok);
        chk("t2_c2", {ok, rd, a, d[13:0]}, {1'b1, 1'b0, 16'h0101, 14'h2AAB});
        wait_cmd(10, a, d, rd, ok);
        chk("t2_c3", {ok, rd, a, d[13:0]}, {1'b1, 1'b0, 16'h0201, 14'h1556});

        // 3: pending read beats pending writes
        do_reset(1'b1);
        repeat (4) step();
        drive_w(0, 16'h0300, 16'h0001); drive_w(1, 16'h0400, 16'h0002);
        step();
        drive_w(0, 16'h0301, 16'h0003); drive_w(1, 16'h0401, 16'h0004);
        step();
        clear_req();
        repeat (3) step();
        drive_r(1, 16'h0033);
        step();
        clear_req();
        repeat (2) step();
        mem_ready = 1'b1;
        wait_cmd(10, a, d, rd, ok);
        chk("t3_held_write", {30'b0, ok, rd}, 2'b10);
        wait_cmd(10, a, d, rd, ok);
        chk("t3_read_next", {15'b0, ok, rd, a}, {15'b0, 1'b1, 1'b1, 16'h0033});

        // 4: three reads return in order to their channels
        do_reset(1'b1);
        repeat (4) step();
        drive_r(0, 16'h0A00); step(); clear_req();
        drive_r(1, 16'h0B00); step(); clear_req();
        drive_r(0, 16'h0A01); step(); clear_req();
        mem_ready = 1'b1;
        wait_cmd(10, a, d, rd, ok);
        chk("t4_rd0", {15'b0, ok, rd, a}, {15'b0, 1'b1, 1'b1, 16'h0A00});
        wait_cmd(10, a, d, rd, ok);
        chk("t4_rd1", {15'b0, ok, rd, a}, {15'b0, 1'b1, 1'b1, 16'h0B00});
        wait_cmd(10, a, d, rd, ok);
        chk("t4_rd2", {15'b0, ok, rd, a}, {15'b0, 1'b1, 1'b1, 16'h0A01});
        chk("t4_idle_rdv", ch_rdv, 0);
        ret_one("t4_ret0", 16'h1111, 2'b01);
        ret_one("t4_ret1", 16'h2222, 2'b10);
        ret_one("t4_ret2", 16'h3333, 2'b01);
        chk("t4_no_orphan", {31'b0, err_orphan}, 0);

        // 6a: return with nothing outstanding
        mem_datavalid = 1'b1;
        mem_rdata     = 16'hDEAD;
        step();
        mem_datavalid = 1'b0;
        chk("t6_orphan_rdv", ch_rdv, 0);
        chk("t6_orphan_flag", {31'b0, err_orphan}, 1);
        step();
        chk("t6_orphan_sticky", {31'b0, err_orphan}, 1);

        // 5: overflow of a write FIFO
        do_reset(1'b0);
        step();
        for (int k = 0; k < 8; k++) begin
            drive_w(0, 16'h0500 + 16'(k), 16'h7000 + 16'(k));
            step();
        end
        clear_req();
        chk("t5_full_at_8", ch_wfull, 2'b01);
        chk("t5_no_ovf_at_8", ch_ovf, 0);
        drive_w(0, 16'h0508, 16'h7008);
        step();
        clear_req();
        chk("t5_ovf", ch_ovf, 2'b01);
        chk("t5_still_full", ch_wfull, 2'b01);
        mem_initdone = 1'b1;
        mem_ready    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_cmd(20, a, d, rd, ok);
            chk("t5_drain", {ok, rd, a, d[13:0]}, {1'b1, 1'b0, 16'h0500 + 16'(k), 14'h3000 + 14'(k)});
        end
        wait_cmd(15, a, d, rd, ok);
        chk("t5_ninth_lost", {31'b0, ok}, 0);
        chk("t5_empty", ch_wempty, 2'b11);

        // 6b: init drop while a command is on the bus
        do_reset(1'b1);
        step();
        drive_w(1, 16'h0777, 16'h1234);
        step();
        clear_req();
        cnt = 0;
        while (cnt < 15 && mem_write !== 1'b1) begin
            step();
            cnt++;
        end
        chk("t6_strobe_up", {31'b0, mem_write}, 1);
        mem_initdone = 1'b0;
        repeat (3) step();
        chk("t6_strobe_masked", {30'b0, mem_write, mem_read}, 0);
        chk("t6_addr_held", mem_address, 16'h0777);
        mem_ready = 1'b1;
        repeat (2) step();
        chk("t6_still_masked", {31'b0, mem_write}, 0);
        mem_initdone = 1'b1;
        wait_cmd(10, a, d, rd, ok);
        chk("t6_reissue", {ok, rd, a, d[13:0]}, {1'b1, 1'b0, 16'h0777, 14'h1234});
        wait_cmd(8, a, d, rd, ok);
        chk("t6_single_issue", {31'b0, ok}, 0);

        // Randomized traffic against the queue model
        do_reset(1'b1);
        exp_rdv = 2'b00;
        exp_rdata = '0;
        seq = 0;
        for (int n = 0; n < 1500; n++) rand_cycle(1'b1);
        for (int n = 0; n < 800 && (wq[0].size() + wq[1].size() + rq[0].size() + rq[1].size()
                                     + retq.size() > 0 || exp_rdv != 2'b00); n++)
            rand_cycle(1'b0);
        chk("rand_drained", wq[0].size() + wq[1].size() + rq[0].size() + rq[1].size() + retq.size(), 0);
        chk("rand_fifos_empty", {ch_wempty, ch_rempty}, 4'b1111);
        chk("rand_no_flags", {ch_ovf, err_orphan}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
